// File: rtl/adc_stream_pkg.sv
// Shared constants for the ADC stream FIFO slice: default widths, the
// drop-counter width and the full-FIFO policy encodings.
package adc_stream_pkg;

  // Default sample width and channel count for the top-level parameters.
  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_NUM_CH      = 4;
  localparam int DEFAULT_DEPTH_WORDS = 64;

  // Optional overflow counter: width and saturation value.
  localparam int                    DROP_CNT_W   = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Full-FIFO policy encodings for the DROP_OLDEST parameter.
  localparam int POLICY_REJECT_NEW  = 0;
  localparam int POLICY_DROP_OLDEST = 1;

  // A single-channel build still carries a 1-bit channel tag.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage : adc_stream_pkg

// File: rtl/adc_fifo_ram.sv
// Storage array for the ADC stream FIFO: one synchronous write port and
// one asynchronous (combinational) read port.
module adc_fifo_ram #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  // NOTE: the array has no reset; validity is tracked by the FIFO count, so
  // clearing it would only add a wide reset network for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Asynchronous read gives first-word-fall-through at the FIFO head.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : adc_fifo_ram

// File: rtl/adc_stream_fifo_mc.sv
// Multi-channel ADC sample FIFO with first-word-fall-through output,
// selectable full policy (reject new / overwrite oldest), flush, watermark
// flag with rising-edge interrupt pulse and a sticky overrun flag.
// Optional feature macro: ADC_FIFO_DROP_COUNT_EN adds a saturating 16-bit
// overflow counter on output drop_count.
module adc_stream_fifo_mc
  import adc_stream_pkg::*;
#(
  parameter  int DATA_W      = DEFAULT_DATA_W,
  parameter  int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter  int NUM_CH      = DEFAULT_NUM_CH,
  parameter  int DROP_OLDEST = POLICY_REJECT_NEW,
  localparam int CH_W        = ch_width(NUM_CH),
  localparam int COUNT_W     = $clog2(DEPTH_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Producer side
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_W-1:0]     push_data,
  input  logic [CH_W-1:0]       push_ch,
  // Consumer side
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_W-1:0]     pop_data,
  output logic [CH_W-1:0]       pop_ch,
  // Control and status
  input  logic                  flush,
  input  logic [COUNT_W-1:0]    wm_level,
  output logic [COUNT_W-1:0]    level_words,
  output logic                  wm_flag,
  output logic                  wm_irq,
  output logic                  overrun_sticky,
  input  logic                  overrun_clear
`ifdef ADC_FIFO_DROP_COUNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);

  localparam int                 ADDR_W     = $clog2(DEPTH_WORDS);
  localparam int                 WORD_W     = DATA_W + CH_W;
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH_WORDS);
  localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);
  localparam logic [ADDR_W-1:0]  PTR_ONE    = ADDR_W'(1);

  // Reject illegal geometries at elaboration time.
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $fatal(1, "adc_stream_fifo_mc: DEPTH_WORDS must be a power of two and >= 2");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $fatal(1, "adc_stream_fifo_mc: NUM_CH must be >= 1");
  end
  if (DROP_OLDEST != POLICY_REJECT_NEW && DROP_OLDEST != POLICY_DROP_OLDEST) begin : g_bad_policy
    $fatal(1, "adc_stream_fifo_mc: DROP_OLDEST must be 0 or 1");
  end

  // State registers and their next-state values.
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               wm_flag_q, wm_flag_d;
  logic               wm_irq_q, wm_irq_d;

  // Handshake and event decode.
  logic full;
  logic empty;
  logic push_fire;
  logic pop_fire;
  logic drop_head;
  logic overflow_evt;
  logic ram_we;
  logic [WORD_W-1:0] rd_word;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // Overwrite-oldest always accepts; reject-new stalls the producer at full.
  assign push_ready = (DROP_OLDEST == POLICY_DROP_OLDEST) ? 1'b1 : !full;
  assign pop_valid  = !empty;

  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop_valid && pop_ready;

  // A push into a full FIFO with no pop frees the head slot by discarding it.
  assign drop_head = push_fire && full && !pop_fire;

  // A producer offering a word the FIFO cannot absorb without loss.
  assign overflow_evt = push_valid && full && !pop_fire && !flush;

  // Flush cancels the write as well as the pointer updates.
  assign ram_we = push_fire && !flush;

  // Pointer and occupancy next-state; flush wins over push and pop.
  // NOTE: every output of this block is given its hold value first so that
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_fire || drop_head) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_fire && !pop_fire && !full) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_fire && !push_fire) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Status next-state: sticky overrun (set beats clear), watermark, edge pulse.
  always_comb begin
    overrun_d = overrun_q;
    if (overflow_evt) begin
      overrun_d = 1'b1;
    end else if (overrun_clear) begin
      overrun_d = 1'b0;
    end
    wm_flag_d = (wm_level != '0) && (count_d >= wm_level);
    wm_irq_d  = wm_flag_d && !wm_flag_q;
  end

  // Register pointers, occupancy and status flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      wm_flag_q <= 1'b0;
      wm_irq_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      wm_flag_q <= wm_flag_d;
      wm_irq_q  <= wm_irq_d;
    end
  end

  assign level_words    = count_q;
  assign overrun_sticky = overrun_q;
  assign wm_flag        = wm_flag_q;
  assign wm_irq         = wm_irq_q;

`ifdef ADC_FIFO_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating overflow counter; a same-cycle increment beats the clear.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_evt) begin
      if (drop_cnt_q != DROP_CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end else if (overrun_clear) begin
      drop_cnt_d = '0;
    end
  end

  // Register the overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  // Sample storage: channel tag travels alongside its sample.
  adc_fifo_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({push_ch, push_data}),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  assign {pop_ch, pop_data} = rd_word;

endmodule : adc_stream_fifo_mc

// File: tb/tb_adc_stream_fifo_mc.sv
// Bench for adc_stream_fifo_mc: one instance per full-FIFO policy driven by
// shared stimulus, each with a queue-based reference model and monitor.
// drop_count is connected and checked when ADC_FIFO_DROP_COUNT_EN is defined.
module tb_adc_stream_fifo_mc;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic [CW-1:0] push_ch;
  logic          pop_ready;
  logic          flush;
  logic [LW-1:0] wm_level;
  logic          overrun_clear;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar p = 0; p < 2; p++) begin : g_dut
    localparam int P = p;

    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [CW-1:0] pop_ch;
    logic [LW-1:0] level_words;
    logic          wm_flag;
    logic          wm_irq;
    logic          overrun_sticky;
`ifdef ADC_FIFO_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    adc_stream_fifo_mc #(
      .DATA_W      (DW),
      .DEPTH_WORDS (DEPTH),
      .NUM_CH      (NCH),
      .DROP_OLDEST (P)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .push_valid     (push_valid),
      .push_ready     (push_ready),
      .push_data      (push_data),
      .push_ch        (push_ch),
      .pop_valid      (pop_valid),
      .pop_ready      (pop_ready),
      .pop_data       (pop_data),
      .pop_ch         (pop_ch),
      .flush          (flush),
      .wm_level       (wm_level),
      .level_words    (level_words),
      .wm_flag        (wm_flag),
      .wm_irq         (wm_irq),
      .overrun_sticky (overrun_sticky),
      .overrun_clear  (overrun_clear)
`ifdef ADC_FIFO_DROP_COUNT_EN
      ,
      .drop_count     (drop_count)
`endif
    );

    // Reference state: expected contents as {ch, data}, oldest first.
    logic [DW+CW-1:0] mq [$];
    bit               m_ovr;
    bit               m_wm;
    bit               m_irq;
    int               m_drop;

    // Monitor/model: compare outputs, score pops, then apply this cycle's inputs.
    always @(negedge clk) begin : mon
      bit pop_fire;
      bit push_fire;
      bit was_full;
      bit ovf;
      bit new_wm;
      if (!rst_n) begin
        check($sformatf("p%0d rst level", P), 32'(level_words), 0);
        check($sformatf("p%0d rst pop_valid", P), 32'(pop_valid), 0);
        check($sformatf("p%0d rst push_ready", P), 32'(push_ready), 1);
        check($sformatf("p%0d rst overrun", P), 32'(overrun_sticky), 0);
        check($sformatf("p%0d rst wm_flag", P), 32'(wm_flag), 0);
        mq.delete();
        m_ovr  = 0;
        m_wm   = 0;
        m_irq  = 0;
        m_drop = 0;
      end else begin
        check($sformatf("p%0d level", P), 32'(level_words), 32'(mq.size()));
        check($sformatf("p%0d pop_valid", P), 32'(pop_valid), 32'(mq.size() != 0));
        check($sformatf("p%0d push_ready", P), 32'(push_ready),
              32'(P == 1 || mq.size() < DEPTH));
        check($sformatf("p%0d overrun", P), 32'(overrun_sticky), 32'(m_ovr));
        check($sformatf("p%0d wm_flag", P), 32'(wm_flag), 32'(m_wm));
        check($sformatf("p%0d wm_irq", P), 32'(wm_irq), 32'(m_irq));
`ifdef ADC_FIFO_DROP_COUNT_EN
        check($sformatf("p%0d drop_count", P), 32'(drop_count), 32'(m_drop));
`endif
        was_full  = (mq.size() == DEPTH);
        pop_fire  = pop_ready && (mq.size() != 0);
        push_fire = push_valid && (P == 1 || !was_full);
        ovf       = push_valid && was_full && !pop_fire && !flush;
        if (pop_fire) begin
          check($sformatf("p%0d pop word", P), 32'({pop_ch, pop_data}), 32'(mq[0]));
        end
        if (flush) begin
          mq.delete();
        end else begin
          if (pop_fire) void'(mq.pop_front());
          if (push_fire) begin
            if (mq.size() == DEPTH) void'(mq.pop_front());
            mq.push_back({push_ch, push_data});
          end
        end
        if (ovf) m_ovr = 1;
        else if (overrun_clear) m_ovr = 0;
        if (ovf) m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 1;
        else if (overrun_clear) m_drop = 0;
        new_wm = (wm_level != 0) && (mq.size() >= int'(wm_level));
        m_irq  = new_wm && !m_wm;
        m_wm   = new_wm;
      end
    end

    // Asynchronous reset must take effect without waiting for a clock edge.
    always @(negedge rst_n) begin
      #1;
      check($sformatf("p%0d async rst level", P), 32'(level_words), 0);
      check($sformatf("p%0d async rst pop_valid", P), 32'(pop_valid), 0);
      check($sformatf("p%0d async rst push_ready", P), 32'(push_ready), 1);
      check($sformatf("p%0d async rst wm_irq", P), 32'(wm_irq), 0);
    end
  end

  task automatic idle();
    push_valid    = 1'b0;
    pop_ready     = 1'b0;
    flush         = 1'b0;
    overrun_clear = 1'b0;
  endtask

  // Let one rising edge consume the current inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_data  = DW'(first + i);
      push_ch    = CW'(i % NCH);
      cyc();
    end
    idle();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      int pb;
      int rb;
      pb = ((i / 200) % 2 == 1) ? 80 : 30;
      rb = ((i / 200) % 2 == 1) ? 30 : 80;
      push_valid    = ($urandom_range(0, 99) < pb);
      push_data     = DW'($urandom());
      push_ch       = CW'($urandom_range(0, NCH - 1));
      pop_ready     = ($urandom_range(0, 99) < rb);
      flush         = ($urandom_range(0, 63) == 0);
      overrun_clear = ($urandom_range(0, 15) == 0);
      if (i % 64 == 0) wm_level = LW'($urandom_range(0, DEPTH));
      cyc();
    end
    idle();
  endtask

  initial begin
    rst_n     = 1'b0;
    push_data = '0;
    push_ch   = '0;
    wm_level  = '0;
    idle();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Fill both FIFOs with 1..8; reject-new instance stalls the producer.
    push_words(1, 8);
    @(negedge clk);
    check("fill p0 level", 32'(g_dut[0].level_words), 8);
    check("fill p0 push_ready", 32'(g_dut[0].push_ready), 0);
    check("fill p1 level", 32'(g_dut[1].level_words), 8);
    cyc();

    // Overflow at full, then clear the sticky flag.
    push_valid = 1'b1;
    push_data  = 24'hABCDEF;
    push_ch    = 2'd1;
    cyc();
    idle();
    @(negedge clk);
    check("ovf p0 overrun", 32'(g_dut[0].overrun_sticky), 1);
    check("ovf p0 level", 32'(g_dut[0].level_words), 8);
`ifdef ADC_FIFO_DROP_COUNT_EN
    check("ovf p0 drop_count", 32'(g_dut[0].drop_count), 1);
`endif
    cyc();
    overrun_clear = 1'b1;
    cyc();
    idle();
    @(negedge clk);
    check("clr p0 overrun", 32'(g_dut[0].overrun_sticky), 0);
`ifdef ADC_FIFO_DROP_COUNT_EN
    check("clr p0 drop_count", 32'(g_dut[0].drop_count), 0);
`endif
    cyc();
    pop_ready = 1'b1;
    repeat (8) cyc();
    idle();

    // Overwrite-oldest: 1..8 then 9 leaves 2..9.
    push_words(1, 9);
    @(negedge clk);
    check("drop p1 level", 32'(g_dut[1].level_words), 8);
    check("drop p1 head", 32'(g_dut[1].pop_data), 2);
    cyc();
    pop_ready = 1'b1;
    repeat (7) cyc();
    @(negedge clk);
    check("drop p1 last", 32'(g_dut[1].pop_data), 9);
    cyc();
    idle();
    overrun_clear = 1'b1;
    cyc();
    idle();

    // Watermark at 5: flag after the 5th push, one-cycle irq, drop after a pop.
    wm_level = 4'd5;
    push_words(16'h100, 5);
    @(negedge clk);
    check("wm p0 flag", 32'(g_dut[0].wm_flag), 1);
    check("wm p0 irq", 32'(g_dut[0].wm_irq), 1);
    cyc();
    @(negedge clk);
    check("wm p0 irq gone", 32'(g_dut[0].wm_irq), 0);
    check("wm p0 flag held", 32'(g_dut[0].wm_flag), 1);
    cyc();
    pop_ready = 1'b1;
    cyc();
    idle();
    @(negedge clk);
    check("wm p0 flag after pop", 32'(g_dut[0].wm_flag), 0);
    cyc();
    wm_level = '0;

    // Flush priority with overrun already set.
    flush = 1'b1;
    cyc();
    idle();
    push_words(16'h200, 9);
    flush = 1'b1;
    cyc();
    idle();
    push_words(16'h300, 3);
    push_valid = 1'b1;
    push_data  = 24'h777777;
    pop_ready  = 1'b1;
    flush      = 1'b1;
    cyc();
    idle();
    @(negedge clk);
    check("flush p0 level", 32'(g_dut[0].level_words), 0);
    check("flush p0 pop_valid", 32'(g_dut[0].pop_valid), 0);
    check("flush p0 overrun kept", 32'(g_dut[0].overrun_sticky), 1);
    check("flush p1 overrun kept", 32'(g_dut[1].overrun_sticky), 1);
    cyc();

    // Randomised traffic, reset mid-burst, then more traffic.
    random_run(1200);
    push_valid = 1'b1;
    push_data  = 24'h5A5A5A;
    cyc();
    #2;
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    random_run(600);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adc_stream_fifo_mc

// File: doc/adc_stream_fifo_mc.md
ADC_STREAM_FIFO_MC -- requirements
Module: adc_stream_fifo_mc

Interface
REQ-001 Parameter DATA_W, default 32: sample word width in bits.
REQ-002 Parameter DEPTH_WORDS, default 64: entries; power of two and >= 2, else elaboration SHALL fail with $fatal.
REQ-003 Parameter NUM_CH, default 4: source channels; >= 1.
REQ-004 Parameter DROP_OLDEST, default 0: full-FIFO policy; 0 = reject new word, 1 = overwrite oldest word.
REQ-005 Derived widths: CH_W = max(1,$clog2(NUM_CH)); COUNT_W = $clog2(DEPTH_WORDS+1).
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 push_valid / push_ready  in / out  1 / 1  producer handshake.
REQ-009 push_data / push_ch  in  DATA_W / CH_W  sample and channel tag.
REQ-010 pop_valid / pop_ready  out / in  1 / 1  consumer handshake.
REQ-011 pop_data / pop_ch  out  DATA_W / CH_W  head sample and its tag.
REQ-012 flush  in  1  synchronous empty request.
REQ-013 wm_level  in  COUNT_W  watermark threshold; 0 disables the watermark.
REQ-014 level_words  out  COUNT_W  current occupancy.
REQ-015 wm_flag / wm_irq  out  1 / 1  level-at-or-above-watermark flag and its one-cycle rising-edge pulse.
REQ-016 overrun_sticky / overrun_clear  out / in  1 / 1  overflow flag and its clear (register-level W1C drives overrun_clear).

Function
REQ-017 Storage: first-word-fall-through; a word pushed in cycle N SHALL appear on pop_data/pop_ch with pop_valid=1 in cycle N+1.
REQ-018 Handshakes: push occurs when push_valid&&push_ready; pop occurs when pop_valid&&pop_ready; pop_valid = (count != 0).
REQ-019 DROP_OLDEST=0: push_ready = (count != DEPTH_WORDS); a rejected push SHALL NOT alter storage or pointers.
REQ-020 DROP_OLDEST=1: push_ready is held at 1; on a push when full without a pop, the word SHALL be written, both pointers SHALL advance, and count SHALL stay at DEPTH_WORDS.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including at full and at empty (at empty only the push takes effect).
REQ-022 Pointers are ADDR_W = $clog2(DEPTH_WORDS) bits wide and SHALL wrap modulo DEPTH_WORDS.
REQ-023 flush SHALL zero the pointers and count on the next edge, SHALL take priority over a same-cycle push or pop, and SHALL NOT clear overrun_sticky.
REQ-024 Overflow event = push_valid && count==DEPTH_WORDS && !pop occurring && !flush; it SHALL set overrun_sticky in both policies.
REQ-025 When overrun_clear and an overflow event occur in the same cycle, the set SHALL win.
REQ-026 wm_flag SHALL be registered and equal 1 iff wm_level != 0 and the next count >= wm_level.
REQ-027 wm_irq SHALL be a registered one-cycle pulse on each 0->1 transition of wm_flag.

Reset
REQ-028 While rst_n is 0, the block SHALL hold pointers, count, overrun_sticky, wm_flag, wm_irq and the drop counter at 0, giving push_ready=1, pop_valid=0 and level_words=0.
REQ-029 An assertion of rst_n mid-transfer SHALL discard all contents; memory contents are not reset and pop_data is don't-care while pop_valid=0.

Configuration
REQ-030 With ADC_FIFO_DROP_COUNT_EN defined, the block SHALL add output drop_count[15:0], which increments on each overflow event, saturates at 0xFFFF, and is cleared by overrun_clear (an increment wins over the clear in the same cycle).
REQ-031 Without ADC_FIFO_DROP_COUNT_EN, the drop_count port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package adc_stream_pkg SHALL hold the default DATA_W/NUM_CH constants, the drop-counter width (16), and the DROP_OLDEST policy encodings.
REQ-033 Storage SHALL be a sub-module adc_fifo_ram (DATA_W+CH_W wide, DEPTH_WORDS deep, one write port, asynchronous read) instantiated once.

Verification (DATA_W=24, DEPTH_WORDS=8, NUM_CH=4)
REQ-034 Reset, then push 0x000001..0x000008 tagged ch 0..3 repeating -> count reaches 8, push_ready=0, and the pops return the same values and tags in order.
REQ-035 DROP_OLDEST=0, full, push 0xABCDEF -> word rejected, overrun_sticky=1, drop_count=1; then pulse overrun_clear -> both read 0.
REQ-036 DROP_OLDEST=1, full of 1..8, push 9 -> count=8, first pop returns 2 and the last pop returns 9.
REQ-037 wm_level=5, push 5 words -> wm_flag=1 after the 5th push and wm_irq high exactly one cycle; pop 1 -> wm_flag=0.
REQ-038 Count=3 with push, pop and flush all asserted in one cycle -> count=0 and pop_valid=0 next cycle, overrun_sticky unchanged; drive rst_n low mid-burst -> outputs take their reset values immediately.
